// File: rtl/usb_fs_tx_serializer.sv
// usb_fs_tx_serializer: USB full-speed transmitter (SYNC, NRZI, bit stuffing, EOP).
// Define USB_TX_CRC16_EN to append CRC16 to DATA packets with a payload.
module usb_fs_tx_serializer #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int IPG_BITS       = 2
) (
    input  logic       clock48,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       usb_dp_out,
    output logic       usb_dn_out,
    output logic       usb_oe,
    output logic       busy,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J,
        GAP
    } state_t;

    localparam logic [1:0] LAST_TICK = 2'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0] LAST_GAP  = 3'(IPG_BITS - 1);

    state_t     state;
    logic [1:0] bit_cnt;
    logic [2:0] idx;
    logic [2:0] ones;
    logic [7:0] hold;
    logic [7:0] shift;
    logic       hold_last;
    logic       hold_full;
    logic       shift_last;

    logic strobe;
    logic stuff_now;
    logic sync_end;
    logic byte_end;
    logic go_pop;
    logic go_eop;
    logic go_urun;
    logic hold_pop;
    logic accept;
    logic do_emit;
    logic nxt_bit;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc;
    logic        crc_on;
    logic        pid_phase;
    logic [1:0]  crc_ph;
    logic        go_crc_lo;
    logic        go_crc_hi;

    function automatic logic [15:0] crc16_byte(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 16'hA001;
            else
                r = r >> 1;
        end
        return r;
    endfunction
`endif

    assign strobe    = (bit_cnt == LAST_TICK);
    assign stuff_now = (ones == 3'd6);
    assign sync_end  = strobe && (state == SYNC) && (idx == 3'd7);
    assign byte_end  = strobe && (state == DATA) && !stuff_now
                       && (idx == 3'd7);

    // Decide what happens when the current byte's last bit finishes.
    always_comb begin
        go_pop  = 1'b0;
        go_eop  = 1'b0;
        go_urun = 1'b0;
        if (byte_end) begin
            if (shift_last)
                go_eop = 1'b1;
            else if (hold_full)
                go_pop = 1'b1;
            else
                go_urun = 1'b1;
        end
`ifdef USB_TX_CRC16_EN
        go_crc_lo = byte_end && (crc_ph == 2'd0) && shift_last
                    && crc_on && !pid_phase;
        go_crc_hi = byte_end && (crc_ph == 2'd1);
        if ((crc_ph != 2'd0) || go_crc_lo) begin
            go_eop  = byte_end && (crc_ph == 2'd2);
            go_pop  = 1'b0;
            go_urun = 1'b0;
        end
`endif
    end

    assign hold_pop = sync_end || go_pop;
`ifdef USB_TX_CRC16_EN
    assign in_ready = (!hold_full || hold_pop) && (crc_ph == 2'd0);
`else
    assign in_ready = !hold_full || hold_pop;
`endif
    assign accept   = in_valid && in_ready;
    assign do_emit  = strobe && ((state == SYNC) ||
                      ((state == DATA) && !go_eop && !go_urun));

    // Select the logical value of the next bit placed on the line.
    always_comb begin
        nxt_bit = 1'b0;
        if (state == SYNC)
            nxt_bit = (idx == 3'd7) ? hold[0] : (idx == 3'd6);
        else if (stuff_now)
            nxt_bit = 1'b0;
        else if (idx != 3'd7)
            nxt_bit = shift[1];
        else if (go_pop)
            nxt_bit = hold[0];
`ifdef USB_TX_CRC16_EN
        else if (go_crc_lo)
            nxt_bit = ~crc[0];
        else if (go_crc_hi)
            nxt_bit = ~crc[8];
`endif
    end

    // Holding register, bit timing, NRZI line state and packet FSM.
    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 2'd0;
            idx         <= 3'd0;
            ones        <= 3'd0;
            hold        <= 8'd0;
            hold_last   <= 1'b0;
            hold_full   <= 1'b0;
            shift       <= 8'd0;
            shift_last  <= 1'b0;
            usb_oe      <= 1'b0;
            usb_dp_out  <= 1'b1;
            usb_dn_out  <= 1'b0;
            busy        <= 1'b0;
            tx_underrun <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc         <= 16'hFFFF;
            crc_on      <= 1'b0;
            pid_phase   <= 1'b0;
            crc_ph      <= 2'd0;
`endif
        end else begin
            tx_underrun <= 1'b0;

            if (accept) begin
                hold      <= in_data;
                hold_last <= in_last;
                hold_full <= 1'b1;
            end else if (hold_pop) begin
                hold_full <= 1'b0;
            end

            if (state == IDLE)
                bit_cnt <= 2'd0;
            else
                bit_cnt <= bit_cnt + 2'd1;

            if (do_emit) begin
                if (nxt_bit) begin
                    ones <= ones + 3'd1;
                end else begin
                    ones       <= 3'd0;
                    usb_dp_out <= usb_dn_out;
                    usb_dn_out <= usb_dp_out;
                end
            end

            unique case (state)
                IDLE: begin
                    if (hold_full) begin
                        state      <= SYNC;
                        usb_oe     <= 1'b1;
                        busy       <= 1'b1;
                        idx        <= 3'd0;
                        ones       <= 3'd0;
                        usb_dp_out <= 1'b0;
                        usb_dn_out <= 1'b1;
                    end
                end
                SYNC: begin
                    if (strobe) begin
                        if (idx == 3'd7) begin
                            state      <= DATA;
                            idx        <= 3'd0;
                            shift      <= hold;
                            shift_last <= hold_last;
`ifdef USB_TX_CRC16_EN
                            crc        <= 16'hFFFF;
                            crc_on     <= (hold[1:0] == 2'b11);
                            pid_phase  <= 1'b1;
                            crc_ph     <= 2'd0;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                DATA: begin
                    if (strobe && !stuff_now) begin
                        if (idx != 3'd7) begin
                            shift <= shift >> 1;
                            idx   <= idx + 3'd1;
                        end else if (go_pop) begin
                            shift      <= hold;
                            shift_last <= hold_last;
                            idx        <= 3'd0;
`ifdef USB_TX_CRC16_EN
                            crc        <= crc16_byte(crc, hold);
                            pid_phase  <= 1'b0;
                        end else if (go_crc_lo) begin
                            shift  <= ~crc[7:0];
                            idx    <= 3'd0;
                            crc_ph <= 2'd1;
                        end else if (go_crc_hi) begin
                            shift  <= ~crc[15:8];
                            idx    <= 3'd0;
                            crc_ph <= 2'd2;
`endif
                        end else if (go_eop || go_urun) begin
                            state       <= EOP_SE0;
                            idx         <= 3'd0;
                            usb_dp_out  <= 1'b0;
                            usb_dn_out  <= 1'b0;
                            tx_underrun <= go_urun;
                        end
                    end
                end
                EOP_SE0: begin
                    if (strobe) begin
                        if (idx == 3'd1) begin
                            state      <= EOP_J;
                            usb_dp_out <= 1'b1;
                            usb_dn_out <= 1'b0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                EOP_J: begin
                    if (strobe) begin
                        state  <= GAP;
                        usb_oe <= 1'b0;
                        idx    <= 3'd0;
                    end
                end
                GAP: begin
                    if (strobe) begin
                        if (idx == LAST_GAP) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fs_tx_serializer.sv
// tb_usb_fs_tx_serializer: scoreboard bench for the USB FS transmitter.
// Expected line symbols per packet: J, K, 0 (SE0), one per bit time.
module tb_usb_fs_tx_serializer;

    logic       clock48 = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       usb_dp_out;
    logic       usb_dn_out;
    logic       usb_oe;
    logic       busy;
    logic       tx_underrun;

    usb_fs_tx_serializer dut (
        .clock48     (clock48),
        .reset       (reset),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .usb_dp_out  (usb_dp_out),
        .usb_dn_out  (usb_dn_out),
        .usb_oe      (usb_oe),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    always #5 clock48 = ~clock48;

    typedef struct {
        string sym;
        int    clocks;
        int    urun;
        bit    abort;
    } exp_t;

    exp_t  exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic chk_str(input string name, input string act,
                           input string req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %s, want %s", name, act, req);
        end
    endtask

    task automatic push(input string s, input int clocks,
                        input int urun, input bit abort);
        exp_t e;
        e.sym    = s;
        e.clocks = clocks;
        e.urun   = urun;
        e.abort  = abort;
        exp_q.push_back(e);
    endtask

    function automatic string sym(input logic dp, input logic dn);
        if (dp && !dn)
            return "J";
        if (!dp && dn)
            return "K";
        if (!dp && !dn)
            return "0";
        return "X";
    endfunction

    // Monitor: capture one symbol per bit time while usb_oe is high.
    logic  prev_oe = 1'b0;
    int    cyc     = 0;
    int    urun    = 0;
    int    gap     = 0;
    bit    gap_ok  = 1'b0;
    string cap     = "";
    exp_t  got;

    always @(negedge clock48) begin
        if (usb_oe) begin
            if (!prev_oe) begin
                if (gap_ok) begin
                    n_chk++;
                    if (gap < 8) begin
                        n_fail++;
                        $display("FAIL idle_gap: %0d clocks, want >= 8",
                                 gap);
                    end
                end
                cyc  = 0;
                urun = 0;
                cap  = "";
            end
            if (cyc % 4 == 1)
                cap = {cap, sym(usb_dp_out, usb_dn_out)};
            if (tx_underrun)
                urun++;
            cyc++;
        end else begin
            if (prev_oe) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_packet: got %s, want none", cap);
                    gap_ok = 1'b0;
                end else begin
                    got = exp_q.pop_front();
                    chk_str("symbols", cap, got.sym);
                    chk("oe_clocks", cyc, got.clocks);
                    chk("underrun_cycles", urun, got.urun);
                    if (!got.abort)
                        chk("busy_at_eop", int'(busy), 1);
                    gap_ok = !got.abort;
                end
                gap = 0;
            end
            gap++;
        end
        prev_oe = usb_oe;
    end

    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t        = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && t < 2000) begin
            @(posedge clock48);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: byte %h not taken, want taken", d);
        end else begin
            @(posedge clock48);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(posedge clock48);
            #1;
            t++;
        end
        chk("drain_in_time", int'(t < 5000), 1);
        repeat (4) @(posedge clock48);
        #1;
    endtask

    string s_sync;
    int    t_oe;

    initial begin
        s_sync   = "KJKJKJKK";
        reset    = 1'b1;
        in_data  = 8'h00;
        in_last  = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clock48);
        #1;
        chk("rst_oe", int'(usb_oe), 0);
        chk("rst_dp", int'(usb_dp_out), 1);
        chk("rst_dn", int'(usb_dn_out), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_underrun", int'(tx_underrun), 0);
        reset = 1'b0;
        @(posedge clock48);
        #1;

        // ACK handshake: 0xD2
        push({s_sync, "JJKJJKKK", "00J"}, 76, 0, 1'b0);
        send(8'hD2, 1'b1);
        wait_done();

`ifndef USB_TX_CRC16_EN
        // One stuffed bit after bit 3 of 0xFF
        push({s_sync, "KKJKJKKK", "KKKKJJJJJ", "00J"}, 112, 0, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hFF, 1'b1);
        wait_done();
`else
        // Zero-length DATA1: PID only, no CRC
        push({s_sync, "KKJJKJJK", "00J"}, 76, 0, 1'b0);
        send(8'h4B, 1'b1);
        wait_done();
        // DATA0 with one 0x00 byte, CRC bytes 0x40 then 0xBF
        push({s_sync, "KKJKJKKK", "JKJKJKJK", "JKJKJKKJ",
              "JJJJJJKJJ", "00J"}, 176, 0, 1'b0);
        send(8'hC3, 1'b0);
        send(8'h00, 1'b1);
        wait_done();
`endif

        // Underrun: byte without in_last and nothing behind it
        push({s_sync, "KKJKJKKK", "00J"}, 76, 1, 1'b0);
        send(8'hC3, 1'b0);
        wait_done();

        // Reset at PID bit 4
        push({s_sync, "JJKJ"}, 48, 0, 1'b1);
        send(8'hD2, 1'b1);
        t_oe = 0;
        while (!usb_oe && t_oe < 100) begin
            @(posedge clock48);
            #1;
            t_oe++;
        end
        chk("oe_rise_in_time", int'(usb_oe), 1);
        repeat (48) @(posedge clock48);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_oe", int'(usb_oe), 0);
        chk("midrst_dp", int'(usb_dp_out), 1);
        chk("midrst_dn", int'(usb_dn_out), 0);
        @(posedge clock48);
        #1;
        reset = 1'b0;
        @(posedge clock48);
        #1;
        chk("postrst_in_ready", int'(in_ready), 1);
        chk("postrst_busy", int'(busy), 0);
        wait_done();

        // Back-to-back ACKs, second queued during the first EOP
        push({s_sync, "JJKJJKKK", "00J"}, 76, 0, 1'b0);
        push({s_sync, "JJKJJKKK", "00J"}, 76, 0, 1'b0);
        send(8'hD2, 1'b1);
        t_oe = 0;
        while (!(usb_oe && !usb_dp_out && !usb_dn_out) && t_oe < 200) begin
            @(posedge clock48);
            #1;
            t_oe++;
        end
        chk("reach_eop", int'(t_oe < 200), 1);
        send(8'hD2, 1'b1);
        wait_done();

        chk("leftover_expected", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
